fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction fetch stage that sits directly upstream of the decode stage. It owns the program counter and runs a single-outstanding request/ack handshake to instruction memory. It also holds the IF/ID pipeline register that supplies decode with instruction, PC and valid. It honours decode-side stalls and branch/jump redirects from execute, and inserts NOP bubbles when no instruction is available.

Parameters:
WIDTH, 32, datapath and address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0013, encoding driven on instr_out for bubbles (addi x0,x0,0)

Ports:
clk_in  input  1  clock; all state updates on rising edge
rst_in  input  1  synchronous active-high reset
stall_in  input  1  decode cannot accept; IF/ID register holds
redirect_in  input  1  taken branch/jump from execute; flush and refetch
redirect_pc_in  input  WIDTH  redirect target
imem_req_out  output  1  fetch request valid
imem_addr_out  output  WIDTH  fetch address (word aligned)
imem_ack_in  input  1  data valid for current request; may arrive in the same cycle as req
imem_rdata_in  input  WIDTH  fetched instruction, valid when ack
instr_out  output  WIDTH  IF/ID instruction to decode
pc_out  output  WIDTH  IF/ID PC of instr_out
pc4_out  output  WIDTH  pc_out + 4
valid_out  output  1  instr_out is a real instruction

Behaviour:
- Reset values: pc=RESET_PC; state=FETCH; instr_out=NOP_INSTR; pc_out=0; valid_out=0; imem_req_out=0 while rst_in is high. Reset mid-transaction abandons any outstanding request; memory must tolerate a dropped req.
- Bus rule: while imem_req_out=1 and ack=0, imem_addr_out must stay stable. imem_addr_out=pc in FETCH and pc_hold in DRAIN. Only one request is ever outstanding.
- Arithmetic: pc+4 wraps modulo 2^WIDTH. Redirect target is forced aligned with bits [1:0]=0. pc4_out is combinational from pc_out.
- FSM states: FETCH, WAIT_ID, DRAIN.
- FETCH: imem_req_out=1.
  - ack & !stall: IF/ID <= {rdata, pc, valid=1}; pc <= pc+4; stay in FETCH. This gives back-to-back fetch, one instruction per cycle with zero-wait memory.
  - ack & stall: rdata -> skid buffer (instr, pc); IF/ID holds; pc unchanged; go to WAIT_ID.
  - !ack & !stall: IF/ID <= bubble (NOP_INSTR, valid=0; pc_out holds).
  - !ack & stall: IF/ID holds.
- WAIT_ID: imem_req_out=0. When !stall: IF/ID <= skid contents with valid=1; pc <= pc+4; go to FETCH. While stalled, everything holds.
- DRAIN: imem_req_out=1 at the old address, waiting for the ack. The ack is discarded and never reaches IF/ID. On ack: pc <= pending target; go to FETCH. IF/ID stays a bubble throughout.
- Redirect has highest priority, overrides stall, and always flushes IF/ID to a bubble in the same edge.
  - FETCH & ack: drop rdata; pc <= target; stay in FETCH.
  - FETCH & !ack: pending <= target; pc_hold <= pc; go to DRAIN.
  - WAIT_ID: drop skid; pc <= target; go to FETCH.
  - DRAIN: pending <= newest target. If ack arrives in the same cycle, go to FETCH at the newest target.
- Latency: the instruction appears on instr_out the cycle after its ack, provided it is not stalled or redirected.

Test Plan:
1. Reset then zero-wait memory (ack=req, rdata=0x00A00093 at addr 0) -> first cycle after reset: req=1, addr=0. Next edge: instr_out=0x00A00093, pc_out=0, pc4_out=4, valid_out=1. addr increments by 4 each cycle.
2. Memory with 2-cycle ack latency -> addr held stable across the wait. valid_out=0 with instr_out=0x00000013 on non-ack cycles. Each instruction appears once, in order.
3. stall_in for 3 cycles coinciding with ack at pc=0x8 -> IF/ID holds the pc=0x4 instruction; req=0 in WAIT_ID. After the stall drops: pc_out=0x8, valid_out=1, next req addr=0xC. No instruction is lost or duplicated.
4. redirect_in with target 0x100 during a zero-wait stream -> next edge valid_out=0, and the following fetch addr=0x100. Target 0x102 -> fetch addr 0x100.
5. redirect_in while a request to 0x20 is outstanding (ack 2 cycles later), plus a second redirect to 0x200 during DRAIN -> addr stays 0x20 until the ack, that data is discarded, and the next request addr=0x200.
6. pc=0xFFFF_FFFC fetched, and rst_in asserted mid-stall -> pc wraps to 0x0. Reset returns instr_out=0x13, valid_out=0, and addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding
// req/ack fetch to imem and drives the IF/ID register toward decode.
module fetch_stage #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter logic [WIDTH-1:0] NOP_INSTR = 'h13
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             stall_in,
  input  logic             redirect_in,
  input  logic [WIDTH-1:0] redirect_pc_in,
  output logic             imem_req_out,
  output logic [WIDTH-1:0] imem_addr_out,
  input  logic             imem_ack_in,
  input  logic [WIDTH-1:0] imem_rdata_in,
  output logic [WIDTH-1:0] instr_out,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc4_out,
  output logic             valid_out
);

  localparam logic [WIDTH-1:0] FOUR = 'd4;

  typedef enum logic [1:0] {
    FETCH,
    WAIT_ID,
    DRAIN
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] skid_i_q, skid_i_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pco_q, pco_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] target;

  assign target = {redirect_pc_in[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      hold_q    <= '0;
      pend_q    <= '0;
      skid_i_q  <= '0;
      skid_pc_q <= '0;
      instr_q   <= NOP_INSTR;
      pco_q     <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      hold_q    <= hold_d;
      pend_q    <= pend_d;
      skid_i_q  <= skid_i_d;
      skid_pc_q <= skid_pc_d;
      instr_q   <= instr_d;
      pco_q     <= pco_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    hold_d    = hold_q;
    pend_d    = pend_q;
    skid_i_d  = skid_i_q;
    skid_pc_d = skid_pc_q;
    instr_d   = instr_q;
    pco_d     = pco_q;
    valid_d   = valid_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_in) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (imem_ack_in) begin
            pc_d = target;
          end else begin
            pend_d  = target;
            hold_d  = pc_q;
            state_d = DRAIN;
          end
        end else if (imem_ack_in) begin
          if (stall_in) begin
            skid_i_d  = imem_rdata_in;
            skid_pc_d = pc_q;
            state_d   = WAIT_ID;
          end else begin
            instr_d = imem_rdata_in;
            pco_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + FOUR;
          end
        end else if (!stall_in) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end
      WAIT_ID: begin
        if (redirect_in) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall_in) begin
          instr_d = skid_i_q;
          pco_d   = skid_pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + FOUR;
          state_d = FETCH;
        end
      end
      DRAIN: begin
        // the in-flight response belongs to a squashed path
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (redirect_in) pend_d = target;
        if (imem_ack_in) begin
          pc_d    = redirect_in ? target : pend_q;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  assign imem_req_out  = !rst_in && (state_q != WAIT_ID);
  assign imem_addr_out = (state_q == DRAIN) ? hold_q : pc_q;
  assign instr_out     = instr_q;
  assign pc_out        = pco_q;
  assign pc4_out       = pco_q + FOUR;
  assign valid_out     = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios then random traffic,
// all checked against a flag-based reference model of the stage.
module tb_fetch_stage;

  logic        clk = 0;
  logic        rst_in = 1;
  logic        stall_in = 0;
  logic        redirect_in = 0;
  logic [31:0] redirect_pc_in = '0;
  logic        imem_req_out;
  logic [31:0] imem_addr_out;
  logic        imem_ack_in = 0;
  logic [31:0] imem_rdata_in = '0;
  logic [31:0] instr_out, pc_out, pc4_out;
  logic        valid_out;

  fetch_stage dut (
    .clk_in(clk),
    .rst_in(rst_in),
    .stall_in(stall_in),
    .redirect_in(redirect_in),
    .redirect_pc_in(redirect_pc_in),
    .imem_req_out(imem_req_out),
    .imem_addr_out(imem_addr_out),
    .imem_ack_in(imem_ack_in),
    .imem_rdata_in(imem_rdata_in),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .pc4_out(pc4_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // reference model
  logic [31:0] m_pc = 0, m_hold = 0, m_pend = 0;
  logic [31:0] m_skid = 0, m_instr = 0, m_pco = 0;
  logic        m_v = 0, m_has_skid = 0, m_drain = 0;

  // memory model
  int lat_fix = 0;
  bit mem_busy = 0;
  int mem_left = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0) return 32'h00A00093;
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic cyc(input logic r, input logic s, input logic rd,
                     input logic [31:0] t);
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr, al;
    rst_in = r;
    stall_in = s;
    redirect_in = rd;
    redirect_pc_in = t;
    #1;
    exp_req  = !r && !m_has_skid;
    exp_addr = m_drain ? m_hold : m_pc;
    chk("req", 32'(imem_req_out), 32'(exp_req));
    if (exp_req) chk("addr", imem_addr_out, exp_addr);
    ack = 1'b0;
    if (imem_req_out) begin
      if (!mem_busy) begin
        mem_busy = 1;
        mem_left = (lat_fix < 0) ? int'($urandom_range(0, 3)) : lat_fix;
      end
      ack = (mem_left == 0);
      if (ack) mem_busy = 0;
      else mem_left--;
    end else begin
      mem_busy = 0;
    end
    imem_ack_in = ack;
    imem_rdata_in = ack ? memf(imem_addr_out) : $urandom;
    // model next state from the specified rules
    al = {t[31:2], 2'b00};
    if (r) begin
      m_pc = 0; m_has_skid = 0; m_drain = 0;
      m_instr = 32'h13; m_pco = 0; m_v = 0;
    end else if (m_drain) begin
      if (rd) m_pend = al;
      if (ack) begin
        m_pc = rd ? al : m_pend;
        m_drain = 0;
      end
      m_instr = 32'h13; m_v = 0;
    end else if (m_has_skid) begin
      if (rd) begin
        m_has_skid = 0; m_pc = al;
        m_instr = 32'h13; m_v = 0;
      end else if (!s) begin
        m_has_skid = 0; m_instr = m_skid;
        m_pco = m_pc; m_v = 1; m_pc = m_pc + 4;
      end
    end else if (rd) begin
      m_instr = 32'h13; m_v = 0;
      if (ack) m_pc = al;
      else begin
        m_drain = 1; m_pend = al; m_hold = m_pc;
      end
    end else if (ack) begin
      if (s) begin
        m_has_skid = 1; m_skid = memf(m_pc);
      end else begin
        m_instr = memf(m_pc); m_pco = m_pc;
        m_v = 1; m_pc = m_pc + 4;
      end
    end else if (!s) begin
      m_instr = 32'h13; m_v = 0;
    end
    @(posedge clk);
    #1;
    chk("instr", instr_out, m_instr);
    chk("pc", pc_out, m_pco);
    chk("pc4", pc4_out, m_pco + 32'd4);
    chk("valid", 32'(valid_out), 32'(m_v));
  endtask

  initial begin
    @(posedge clk);
    #1;
    // 1: reset then zero-wait stream
    lat_fix = 0;
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_instr", instr_out, 32'h13);
    chk("rst_valid", 32'(valid_out), 32'd0);
    cyc(0, 0, 0, 0);
    chk("first_instr", instr_out, 32'h00A00093);
    chk("first_pc4", pc4_out, 32'd4);
    cyc(0, 0, 0, 0);
    // 3: stall coincides with ack at pc 0x8
    repeat (3) cyc(0, 1, 0, 0);
    chk("stall_hold_pc", pc_out, 32'h4);
    cyc(0, 0, 0, 0);
    chk("skid_pc", pc_out, 32'h8);
    repeat (3) cyc(0, 0, 0, 0);
    // 4: redirects during zero-wait stream
    cyc(0, 0, 1, 32'h100);
    chk("redir_bubble", 32'(valid_out), 32'd0);
    repeat (3) cyc(0, 0, 0, 0);
    cyc(0, 0, 1, 32'h102);
    repeat (2) cyc(0, 0, 0, 0);
    // 2: two-cycle ack latency
    lat_fix = 2;
    repeat (10) cyc(0, 0, 0, 0);
    // 5: redirect into DRAIN with a second redirect
    lat_fix = 0;
    cyc(0, 0, 1, 32'h20);
    lat_fix = 2;
    cyc(0, 0, 1, 32'h40);
    cyc(0, 0, 1, 32'h200);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("drain_target", imem_addr_out, 32'h200);
    repeat (6) cyc(0, 0, 0, 0);
    // 6: wrap at the top of the address space, reset mid-stall
    lat_fix = 0;
    cyc(0, 0, 1, 32'hFFFF_FFFE);
    cyc(0, 0, 0, 0);
    chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
    chk("wrap_pc4", pc4_out, 32'h0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("rst_mid_instr", instr_out, 32'h13);
    cyc(0, 0, 0, 0);
    chk("after_rst_pc", pc_out, 32'h0);
    // random traffic
    lat_fix = -1;
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
